// File: rtl/fft64_pkg.sv
// Shared constants and state encodings for the 64-point FFT result buffer.
package fft64_pkg;

    localparam int N  = 64;
    localparam int AW = 6;
    localparam int DW = 19;

    localparam logic [AW-1:0] BIN_LAST = AW'(N - 1);

    typedef enum logic [1:0] {C_IDLE, C_FILL, C_DROP} cap_state_e;
    typedef enum logic       {D_IDLE, D_SEND}         drn_state_e;

endpackage

// File: rtl/fft64_bank_ram.sv
// Two result banks of N complex words; the address MSB selects the bank.
module fft64_bank_ram
    import fft64_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [AW:0]       waddr,
    input  logic [2*DW-1:0]   wdata,
    input  logic [AW:0]       raddr,
    output logic [2*DW-1:0]   rdata
);

    logic [2*DW-1:0] mem [2*N];

    // NOTE: storage has no reset; the FULL flags decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft64_result_buffer.sv
// Double-buffered capture of FFT core frames in bin order, replayed over valid/ready.
module fft64_result_buffer
    import fft64_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ed,
    input  logic          rdy,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dor,
    input  logic [DW-1:0] doi,
    input  logic          ovf1,
    input  logic          ovf2,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [AW-1:0] o_bin,
    output logic [DW-1:0] o_re,
    output logic [DW-1:0] o_im,
    output logic          o_last,
    output logic          o_ovf,
    output logic [7:0]    drop_cnt
);

    cap_state_e    cap_state, cap_next;
    logic          cap_bank, bank_next, wr_ptr, frame_ovf, fovf_next;
    logic [AW-1:0] cap_cnt, cnt_next;
    logic [1:0]    full, bank_ovf, bank_free;
    logic          sel_bank, sel_ok, complete, drop_inc;
    logic          ram_we;
    logic [AW:0]   ram_waddr, rd_addr;
    logic [2*DW-1:0] rd_data;

    drn_state_e    drn_state, drn_next;
    logic          rd_ptr, rd_next, release_bank, load, load_bank;
    logic          valid_next, last_next, ovf_next;
    logic [AW-1:0] idx_next;
    logic [DW-1:0] re_next, im_next;

    fft64_bank_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata ({dor, doi}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // A bank handing back its last word this cycle may be refilled at once.
    always_comb begin
        bank_free[0] = !full[0] || (release_bank && !rd_ptr);
        bank_free[1] = !full[1] || (release_bank &&  rd_ptr);
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        cap_next  = cap_state;
        bank_next = cap_bank;
        cnt_next  = cap_cnt;
        fovf_next = frame_ovf;
        ram_we    = 1'b0;
        ram_waddr = {cap_bank, addr};
        complete  = 1'b0;
        drop_inc  = 1'b0;
        sel_bank  = wr_ptr;
        sel_ok    = 1'b0;
        if (bank_free[wr_ptr]) begin
            sel_ok = 1'b1;
        end else if (bank_free[~wr_ptr]) begin
            sel_bank = ~wr_ptr;
            sel_ok   = 1'b1;
        end
        if (ed) begin
            if (rdy) begin
                cnt_next = AW'(1);
                if (sel_ok) begin
                    cap_next  = C_FILL;
                    bank_next = sel_bank;
                    fovf_next = ovf1 | ovf2;
                    ram_we    = 1'b1;
                    ram_waddr = {sel_bank, addr};
                end else begin
                    cap_next = C_DROP;
                    drop_inc = 1'b1;
                end
            end else begin
                case (cap_state)
                    C_FILL: begin
                        ram_we    = 1'b1;
                        cnt_next  = cap_cnt + 1'b1;
                        fovf_next = frame_ovf | ovf1 | ovf2;
                        if (cap_cnt == BIN_LAST) begin
                            complete = 1'b1;
                            cap_next = C_IDLE;
                        end
                    end
                    C_DROP: begin
                        cnt_next = cap_cnt + 1'b1;
                        if (cap_cnt == BIN_LAST) cap_next = C_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_state <= C_IDLE;
            cap_bank  <= 1'b0;
            cap_cnt   <= '0;
            frame_ovf <= 1'b0;
            wr_ptr    <= 1'b0;
            full      <= '0;
            bank_ovf  <= '0;
            drop_cnt  <= '0;
        end else begin
            cap_state <= cap_next;
            cap_bank  <= bank_next;
            cap_cnt   <= cnt_next;
            frame_ovf <= fovf_next;
            if (release_bank) full[rd_ptr] <= 1'b0;
            if (complete) begin
                full[cap_bank]     <= 1'b1;
                bank_ovf[cap_bank] <= fovf_next;
                wr_ptr             <= ~cap_bank;
            end
            if (drop_inc && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // o_bin doubles as the read index of the word currently presented.
    always_comb begin
        drn_next     = drn_state;
        rd_next      = rd_ptr;
        idx_next     = o_bin;
        valid_next   = o_valid;
        last_next    = o_last;
        ovf_next     = o_ovf;
        re_next      = o_re;
        im_next      = o_im;
        release_bank = 1'b0;
        load         = 1'b0;
        load_bank    = rd_ptr;
        case (drn_state)
            D_IDLE: begin
                if (full[rd_ptr]) begin
                    drn_next = D_SEND;
                    idx_next = '0;
                    load     = 1'b1;
                end
            end
            D_SEND: begin
                if (o_ready) begin
                    if (o_bin == BIN_LAST) begin
                        release_bank = 1'b1;
                        rd_next      = ~rd_ptr;
                        idx_next     = '0;
                        if (full[~rd_ptr]) begin
                            load      = 1'b1;
                            load_bank = ~rd_ptr;
                        end else begin
                            drn_next   = D_IDLE;
                            valid_next = 1'b0;
                            last_next  = 1'b0;
                        end
                    end else begin
                        idx_next = o_bin + 1'b1;
                        load     = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        rd_addr = {load_bank, idx_next};
        if (load) begin
            valid_next = 1'b1;
            re_next    = rd_data[2*DW-1:DW];
            im_next    = rd_data[DW-1:0];
            last_next  = (idx_next == BIN_LAST);
            ovf_next   = bank_ovf[load_bank];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drn_state <= D_IDLE;
            rd_ptr    <= 1'b0;
            o_valid   <= 1'b0;
            o_bin     <= '0;
            o_re      <= '0;
            o_im      <= '0;
            o_last    <= 1'b0;
            o_ovf     <= 1'b0;
        end else begin
            drn_state <= drn_next;
            rd_ptr    <= rd_next;
            o_valid   <= valid_next;
            o_bin     <= idx_next;
            o_re      <= re_next;
            o_im      <= im_next;
            o_last    <= last_next;
            o_ovf     <= ovf_next;
        end
    end

endmodule
